// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: 2-bit history counter states,
// reset/allocate values and the branch-type encoding used to derive ex_is_br.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  localparam logic [1:0] BHT_RST   = WNT;
  localparam logic [1:0] BHT_ALLOC = WT;

  // br_type encoding shared with the datapath; anything else is a conditional branch
  localparam logic [2:0] NOBRANCH = 3'd0;

  function automatic logic is_branch(input logic [2:0] br_type);
    return (br_type != NOBRANCH);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating branch history counter: pure combinational next-state logic.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  // saturating step toward ST on taken, toward SNT on not-taken
  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      case (cnt)
        SNT:     cnt_next = WNT;
        WNT:     cnt_next = WT;
        WT:      cnt_next = ST;
        ST:      cnt_next = ST;
        default: cnt_next = cnt;
      endcase
    end else begin
      case (cnt)
        SNT:     cnt_next = SNT;
        WNT:     cnt_next = SNT;
        WT:      cnt_next = WNT;
        ST:      cnt_next = WT;
        default: cnt_next = cnt;
      endcase
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit history counter, EX-stage resolve,
// mispredict/redirect generation and saturating branch statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRY_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_br,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int TAG_W   = 30 - ENTRY_BITS;

  logic              valid_r  [ENTRIES];
  logic [TAG_W-1:0]  tag_r    [ENTRIES];
  logic [31:0]       target_r [ENTRIES];
  logic [1:0]        cnt_r    [ENTRIES];
  logic [31:0]       br_count_r;
  logic [31:0]       miss_count_r;

  logic [ENTRY_BITS-1:0] if_idx_s;
  logic [ENTRY_BITS-1:0] ex_idx_s;
  logic [TAG_W-1:0]      if_tag_s;
  logic [TAG_W-1:0]      ex_tag_s;
  logic                  if_hit_s;
  logic                  ex_hit_s;
  logic                  resolve_s;
  logic [1:0]            cnt_next_s;
  logic                  unused_if_pc_bits_s;

  assign if_idx_s            = if_pc[ENTRY_BITS+1:2];
  assign if_tag_s            = if_pc[31:ENTRY_BITS+2];
  assign ex_idx_s            = ex_pc[ENTRY_BITS+1:2];
  assign ex_tag_s            = ex_pc[31:ENTRY_BITS+2];
  assign resolve_s           = ex_valid && ex_is_br;
  assign unused_if_pc_bits_s = ^if_pc[1:0];

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_r[ex_idx_s]),
    .taken    (ex_br),
    .cnt_next (cnt_next_s)
  );

  // fetch-side lookup; reads pre-update table contents (no bypass)
  always_comb begin
    if_hit_s    = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
    pred_taken  = if_hit_s && cnt_r[if_idx_s][1];
    pred_target = 32'd0;
    if (pred_taken) begin
      pred_target = target_r[if_idx_s];
    end else begin
      pred_target = 32'd0;
    end
  end

  // resolve: compare actual outcome against the prediction carried down the pipe
  always_comb begin
    ex_hit_s    = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
    mispredict  = 1'b0;
    redirect_pc = ex_pc + 32'd4;
    if (resolve_s) begin
      mispredict = (ex_br != ex_pred_taken) ||
                   (ex_br && ex_pred_taken && (ex_pred_target != ex_target));
      if (ex_br) begin
        redirect_pc = ex_target;
      end else begin
        redirect_pc = ex_pc + 32'd4;
      end
    end else begin
      mispredict = 1'b0;
    end
  end

  // valid/counter arrays: reset clears the table, resolve trains or allocates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        cnt_r[i]   <= BHT_RST;
      end
    end else if (resolve_s) begin
      if (ex_hit_s) begin
        cnt_r[ex_idx_s] <= cnt_next_s;
      end else if (ex_br) begin
        valid_r[ex_idx_s] <= 1'b1;
        cnt_r[ex_idx_s]   <= BHT_ALLOC;
      end
    end
  end

  // tag/target arrays carry no reset; a taken resolve always (re)writes both,
  // which on a hit simply rewrites the same tag
  always_ff @(posedge clk) begin
    if (rst_n && resolve_s && ex_br) begin
      tag_r[ex_idx_s]    <= ex_tag_s;
      target_r[ex_idx_s] <= ex_target;
    end
  end

  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count_r   <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (resolve_s) begin
      if (br_count_r != 32'hFFFF_FFFF) begin
        br_count_r <= br_count_r + 32'd1;
      end
      if (mispredict && (miss_count_r != 32'hFFFF_FFFF)) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign br_count   = br_count_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table of per-cycle directed
// vectors followed by a hand-written mid-stream reset sequence.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_br;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(.ENTRY_BITS(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_br       (ex_is_br),
    .ex_pc          (ex_pc),
    .ex_br          (ex_br),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] if_pc;
    logic        ev;
    logic        eb;
    logic [31:0] epc;
    logic        ebr;
    logic [31:0] etgt;
    logic        ept;
    logic [31:0] eptgt;
    logic        x_pt;
    logic [31:0] x_ptgt;
    logic        x_mis;
    logic [31:0] x_redir;
    logic [31:0] x_br;
    logic [31:0] x_miss;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic [31:0] a_if, input logic a_ev, input logic a_eb,
    input logic [31:0] a_epc, input logic a_ebr, input logic [31:0] a_etgt,
    input logic a_ept, input logic [31:0] a_eptgt,
    input logic b_pt, input logic [31:0] b_ptgt, input logic b_mis,
    input logic [31:0] b_redir, input logic [31:0] b_br, input logic [31:0] b_miss);
    vec_t v;
    v.if_pc = a_if;  v.ev = a_ev;  v.eb = a_eb;  v.epc = a_epc;
    v.ebr = a_ebr;   v.etgt = a_etgt; v.ept = a_ept; v.eptgt = a_eptgt;
    v.x_pt = b_pt;   v.x_ptgt = b_ptgt; v.x_mis = b_mis;
    v.x_redir = b_redir; v.x_br = b_br; v.x_miss = b_miss;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_pc          = v.if_pc;
    ex_valid       = v.ev;
    ex_is_br       = v.eb;
    ex_pc          = v.epc;
    ex_br          = v.ebr;
    ex_target      = v.etgt;
    ex_pred_taken  = v.ept;
    ex_pred_target = v.eptgt;
  endtask

  initial begin
    // if_pc, ev, eb, ex_pc, ex_br, ex_target, ex_pt, ex_ptgt | pt, ptgt, mis, redir, br, miss
    // Index of 0x100/0x200 is 0 (tags 1/2); 0x204 is index 1.
    vecs[0]  = mk(32'h100, 1'b0, 1'b0, 32'h40,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h44,  32'd0,  32'd0);
    vecs[1]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  32'd0,  32'd0);
    vecs[2]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104, 32'd1,  32'd1);
    vecs[3]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0,   1'b1, 32'h104, 32'd2,  32'd2);
    vecs[4]  = mk(32'h100, 1'b0, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 32'd3,  32'd3);
    vecs[5]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  32'd3,  32'd3);
    vecs[6]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  32'd4,  32'd4);
    vecs[7]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h90,  1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h90,  32'd5,  32'd5);
    vecs[8]  = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h90,  1'b1, 32'h90,  1'b1, 32'h90,  1'b0, 32'h90,  32'd6,  32'd6);
    vecs[9]  = mk(32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h90,  1'b1, 32'h90,  1'b1, 32'h90,  1'b0, 32'h104, 32'd7,  32'd6);
    vecs[10] = mk(32'h200, 1'b1, 1'b0, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 32'd7,  32'd6);
    vecs[11] = mk(32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0,   1'b1, 32'h90,  1'b1, 32'h300, 32'd7,  32'd6);
    vecs[12] = mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 32'd8,  32'd7);
    vecs[13] = mk(32'h200, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 32'h0, 32'd9,  32'd7);
    vecs[14] = mk(32'h204, 1'b1, 1'b1, 32'h204, 1'b1, 32'h10,  1'b1, 32'h10,  1'b0, 32'h0,   1'b0, 32'h10,  32'd9,  32'd7);
    vecs[15] = mk(32'h204, 1'b1, 1'b1, 32'h204, 1'b0, 32'h10,  1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h208, 32'd10, 32'd7);
    vecs[16] = mk(32'h204, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4,   32'd11, 32'd7);

    rst_n = 1'b0;
    drive(mk(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check("pred_taken",  i, {31'd0, pred_taken}, {31'd0, vecs[i].x_pt});
      check("pred_target", i, pred_target, vecs[i].x_ptgt);
      check("mispredict",  i, {31'd0, mispredict}, {31'd0, vecs[i].x_mis});
      check("redirect_pc", i, redirect_pc, vecs[i].x_redir);
      check("br_count",    i, br_count, vecs[i].x_br);
      check("miss_count",  i, miss_count, vecs[i].x_miss);
    end

    // mid-stream reset with a taken resolve pending in the same cycle
    @(negedge clk);
    rst_n = 1'b0;
    drive(mk(32'h200, 1'b1, 1'b1, 32'h300, 1'b1, 32'h40, 1'b0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0));
    #1;
    check("rst_mispredict", 100, {31'd0, mispredict}, 32'd1);
    check("rst_redirect",   100, redirect_pc, 32'h40);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0));
    #1;
    check("post_rst_br_count",   101, br_count, 32'd0);
    check("post_rst_miss_count", 101, miss_count, 32'd0);
    check("post_rst_pt_200",     101, {31'd0, pred_taken}, 32'd0);
    check("post_rst_ptgt_200",   101, pred_target, 32'd0);
    if_pc = 32'h204;
    #1;
    check("post_rst_pt_204", 102, {31'd0, pred_taken}, 32'd0);
    if_pc = 32'h300;
    #1;
    check("post_rst_pt_300", 103, {31'd0, pred_taken}, 32'd0);

    // fresh allocation after reset still works and counts from zero
    @(negedge clk);
    drive(mk(32'h300, 1'b1, 1'b1, 32'h300, 1'b1, 32'h44, 1'b0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 32'd0, 32'd0));
    @(negedge clk);
    ex_valid = 1'b0;
    ex_is_br = 1'b0;
    #1;
    check("realloc_pt",     104, {31'd0, pred_taken}, 32'd1);
    check("realloc_ptgt",   104, pred_target, 32'h44);
    check("realloc_br",     104, br_count, 32'd1);
    check("realloc_miss",   104, miss_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
